// File: rtl/bsg_manycore_pkg.sv
// Shared wormhole definitions for the manycore edge concentrator:
// header layout, ruche lane indices and the concentrator FSM states.
package bsg_manycore_pkg;

  localparam int WH_FLIT_WIDTH   = 32;
  localparam int WH_CORD_WIDTH   = 16;
  localparam int WH_LEN_WIDTH    = 4;
  localparam int WH_CID_WIDTH    = 5;
  localparam int WH_RUCHE_FACTOR = 2;

  localparam logic WH_LANE0 = 1'b0;
  localparam logic WH_LANE1 = 1'b1;

  // Header flit layout, LSB first: cord, then len, then cid.
  typedef struct packed {
    logic [WH_CID_WIDTH-1:0]  cid;
    logic [WH_LEN_WIDTH-1:0]  len;
    logic [WH_CORD_WIDTH-1:0] cord;
  } wh_header_s;

  // IDLE: heads are headers and are arbitrated. LOCKED: one lane owns the link.
  typedef enum logic {
    WH_ST_IDLE   = 1'b0,
    WH_ST_LOCKED = 1'b1
  } wh_conc_state_e;

endpackage

// File: rtl/bsg_manycore_wh_lane_buffer.sv
// Two-entry ready&valid FIFO for one ruche lane. The ready output comes
// straight from a flop, so the upstream ready path is never combinational.
module bsg_manycore_wh_lane_buffer #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [1:0]         count_q, count_d;
  logic               wr_ptr_q, rd_ptr_q;
  logic               ready_q;
  logic [width_p-1:0] mem_q [2];
  logic               enq, deq;

  assign enq = v_i & ready_q;
  assign deq = yumi_i & (count_q != 2'd0);

  // Occupancy after this cycle's enqueue/dequeue.
  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and the registered ready; ready is low while in reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_q ^ enq;
      rd_ptr_q <= rd_ptr_q ^ deq;
      ready_q  <= (count_d != 2'd2);
    end
  end

  // Storage needs no reset; occupancy qualifies every read.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

  assign ready_and_o = ready_q;
  assign v_o         = (count_q != 2'd0);
  assign data_o      = mem_q[rd_ptr_q];

endmodule

// File: rtl/bsg_manycore_wh_edge_concentrator.sv
// Merges the two west-edge wormhole ruche lanes into one link. Packets are
// granted round-robin at header boundaries and a granted packet keeps the
// link until its last body flit, so flits of different packets never mix.
module bsg_manycore_wh_edge_concentrator
  import bsg_manycore_pkg::*;
#(
  parameter int wh_flit_width_p = 32,
  parameter int wh_cord_width_p = 16,
  parameter int wh_len_width_p  = 4,
  parameter int wh_cid_width_p  = 5
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [1:0]                   in_v_i,
  input  logic [2*wh_flit_width_p-1:0] in_data_i,
  output logic [1:0]                   in_ready_and_o,
  output logic                         out_v_o,
  output logic [wh_flit_width_p-1:0]   out_data_o,
  input  logic                         out_ready_and_i
);

  localparam int hdr_width_lp = wh_cid_width_p + wh_len_width_p + wh_cord_width_p;

  if (hdr_width_lp > wh_flit_width_p) begin : g_bad_hdr
    $error("wormhole header fields do not fit in one flit");
  end

  logic [1:0]                 head_v;
  logic [1:0]                 yumi;
  logic [wh_flit_width_p-1:0] head_data [2];

  for (genvar r = 0; r < WH_RUCHE_FACTOR; r++) begin : g_lane
    bsg_manycore_wh_lane_buffer #(.width_p(wh_flit_width_p)) u_buf (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .v_i         (in_v_i[r]),
      .data_i      (in_data_i[r*wh_flit_width_p +: wh_flit_width_p]),
      .ready_and_o (in_ready_and_o[r]),
      .v_o         (head_v[r]),
      .data_o      (head_data[r]),
      .yumi_i      (yumi[r])
    );
  end

  wh_conc_state_e            state_q, state_d;
  logic                      prio_q, prio_d;
  logic                      lock_lane_q, lock_lane_d;
  logic [wh_len_width_p-1:0] rem_q, rem_d;
  logic                      sel;
  logic                      xfer;
  logic [wh_len_width_p-1:0] head_len;

  // Lane selection: locked lane only, else priority lane first, else the other.
  always_comb begin
    sel     = prio_q;
    out_v_o = 1'b0;
    if (state_q == WH_ST_LOCKED) begin
      sel     = lock_lane_q;
      out_v_o = head_v[lock_lane_q];
    end else if (head_v[prio_q]) begin
      sel     = prio_q;
      out_v_o = 1'b1;
    end else if (head_v[~prio_q]) begin
      sel     = ~prio_q;
      out_v_o = 1'b1;
    end
  end

  assign out_data_o       = head_data[sel];
  assign xfer             = out_v_o & out_ready_and_i;
  assign yumi[WH_LANE0]   = xfer & (sel == WH_LANE0);
  assign yumi[WH_LANE1]   = xfer & (sel == WH_LANE1);
  assign head_len         = out_data_o[wh_cord_width_p +: wh_len_width_p];

  // Next state: lock on a multi-flit header, release after the last body flit.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    lock_lane_d = lock_lane_q;
    rem_d       = rem_q;
    if (xfer) begin
      if (state_q == WH_ST_IDLE) begin
        if (head_len == '0) begin
          prio_d = ~sel;
        end else begin
          state_d     = WH_ST_LOCKED;
          lock_lane_d = sel;
          rem_d       = head_len;
        end
      end else begin
        rem_d = rem_q - 1'b1;
        if (rem_q == {{(wh_len_width_p-1){1'b0}}, 1'b1}) begin
          state_d = WH_ST_IDLE;
          prio_d  = ~lock_lane_q;
        end
      end
    end
  end

  // FSM registers; reset drops any partial packet and returns priority to lane 0.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= WH_ST_IDLE;
      prio_q      <= WH_LANE0;
      lock_lane_q <= WH_LANE0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      lock_lane_q <= lock_lane_d;
      rem_q       <= rem_d;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_wh_edge_concentrator.sv
// Directed bench for the wormhole edge concentrator: per-lane source queues
// feed the inputs, and an expected-flit queue checks every output transfer.
module tb_bsg_manycore_wh_edge_concentrator;
  import bsg_manycore_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    in_v_i;
  logic [2*W-1:0] in_data_i;
  logic [1:0]    in_ready_and_o;
  logic          out_v_o;
  logic [W-1:0]  out_data_o;
  logic          out_ready_and_i;

  logic          v0, v1;
  logic [W-1:0]  d0, d1;
  logic [1:0]    hold_v;

  assign in_v_i    = {v1, v0} | hold_v;
  assign in_data_i = {d1, d0};

  bsg_manycore_wh_edge_concentrator dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .in_v_i          (in_v_i),
    .in_data_i       (in_data_i),
    .in_ready_and_o  (in_ready_and_o),
    .out_v_o         (out_v_o),
    .out_data_o      (out_data_o),
    .out_ready_and_i (out_ready_and_i)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] src0[$];
  logic [W-1:0] src1[$];
  int n_checks = 0;
  int n_errors = 0;
  logic fair_phase = 1'b0;
  int hdr_cnt0 = 0;
  int hdr_cnt1 = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk_hdr(input logic lane, input int seq, input int len);
    wh_header_s h;
    h.cid  = '0;
    h.len  = len[3:0];
    h.cord = 16'h00C0;
    return {lane, 1'b0, seq[4:0], h};
  endfunction

  function automatic logic [W-1:0] mk_body(input logic lane, input int seq, input int k);
    return {lane, 1'b1, seq[4:0], k[24:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- driver: presents each lane queue head, pops on handshake
  initial begin
    logic f0, f1;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    forever begin
      @(negedge clk);
      f0 = v0 && in_ready_and_o[0];
      f1 = v1 && in_ready_and_o[1];
      @(posedge clk);
      #1;
      if (f0 && src0.size() != 0) void'(src0.pop_front());
      if (f1 && src1.size() != 0) void'(src1.pop_front());
      v0 = (src0.size() != 0);
      v1 = (src1.size() != 0);
      d0 = v0 ? src0[0] : '0;
      d1 = v1 ? src1[0] : '0;
    end
  end

  // ---------------- monitor: every output transfer must match the next expected flit
  always @(negedge clk) begin
    if (rst_n && out_v_o && out_ready_and_i) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_v", {31'd0, out_v_o}, 32'd0);
      end else begin
        check("out_flit", out_data_o, exp_q.pop_front());
      end
      if (fair_phase && !out_data_o[30]) begin
        if (out_data_o[31]) hdr_cnt1++;
        else hdr_cnt0++;
      end
    end
  end

  // ---------------- directed sequence
  initial begin
    rst_n = 1'b0;
    hold_v = 2'b11;
    out_ready_and_i = 1'b1;

    // Reset held with both lanes asserting valid.
    repeat (3) tick();
    check("rst_out_v", {31'd0, out_v_o}, 32'd0);
    check("rst_ready", {30'd0, in_ready_and_o}, 32'd0);
    rst_n = 1'b1;
    hold_v = 2'b00;
    #1;
    check("rel_ready_pre_edge", {30'd0, in_ready_and_o}, 32'd0);
    tick();
    check("rel_ready_post_edge", {30'd0, in_ready_and_o}, 32'd3);
    check("rel_out_v", {31'd0, out_v_o}, 32'd0);
    check("rel_prio", {31'd0, dut.prio_q}, 32'd0);
    tick();
    check("rel_no_flit", {31'd0, out_v_o}, 32'd0);

    // Single-flit packets on both lanes in the same cycle.
    src0.push_back(32'h0000_0005);
    src1.push_back(32'h0000_0007);
    exp_q.push_back(32'h0000_0005);
    exp_q.push_back(32'h0000_0007);
    tick();
    check("sf_cycle_n_out_v", {31'd0, out_v_o}, 32'd0);
    tick();
    check("sf_n1_data", out_data_o, 32'h0000_0005);
    tick();
    check("sf_n2_data", out_data_o, 32'h0000_0007);
    wait_drain(10);
    check("sf_prio_back_0", {31'd0, dut.prio_q}, 32'd0);

    // Locking: lane0 4-flit packet, lane1 header one cycle later must wait.
    src0.push_back(mk_hdr(1'b0, 1, 3));
    src0.push_back(mk_body(1'b0, 1, 1));
    src0.push_back(mk_body(1'b0, 1, 2));
    src0.push_back(mk_body(1'b0, 1, 3));
    exp_q.push_back(mk_hdr(1'b0, 1, 3));
    exp_q.push_back(mk_body(1'b0, 1, 1));
    exp_q.push_back(mk_body(1'b0, 1, 2));
    exp_q.push_back(mk_body(1'b0, 1, 3));
    exp_q.push_back(mk_hdr(1'b1, 2, 0));
    tick();
    src1.push_back(mk_hdr(1'b1, 2, 0));
    tick();
    tick();
    check("lock_b1_not_lane1", out_data_o, mk_body(1'b0, 1, 1));
    check("lock_state", {31'd0, dut.state_q}, {31'd0, WH_ST_LOCKED});
    wait_drain(20);
    check("lock_prio_after", {31'd0, dut.prio_q}, 32'd0);

    // Backpressure: downstream stalls while lane0 streams four single-flit packets.
    out_ready_and_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src0.push_back(mk_hdr(1'b0, 8 + i, 0));
      exp_q.push_back(mk_hdr(1'b0, 8 + i, 0));
    end
    tick();
    check("bp_ready_a", {31'd0, in_ready_and_o[0]}, 32'd1);
    tick();
    check("bp_ready_a1", {31'd0, in_ready_and_o[0]}, 32'd1);
    check("bp_data_a1", out_data_o, mk_hdr(1'b0, 8, 0));
    tick();
    check("bp_ready_full", {31'd0, in_ready_and_o[0]}, 32'd0);
    check("bp_data_a2", out_data_o, mk_hdr(1'b0, 8, 0));
    check("bp_state_idle", {31'd0, dut.state_q}, {31'd0, WH_ST_IDLE});
    tick();
    check("bp_data_a3", out_data_o, mk_hdr(1'b0, 8, 0));
    check("bp_out_v", {31'd0, out_v_o}, 32'd1);
    out_ready_and_i = 1'b1;
    wait_drain(20);
    check("bp_prio_after", {31'd0, dut.prio_q}, 32'd1);

    // Fairness: both lanes stream len=1 packets; lane1 holds priority first.
    for (int i = 0; i < 10; i++) begin
      src0.push_back(mk_hdr(1'b0, i, 1));
      src0.push_back(mk_body(1'b0, i, 7));
      src1.push_back(mk_hdr(1'b1, i, 1));
      src1.push_back(mk_body(1'b1, i, 7));
    end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk_hdr(1'b1, i, 1));
      exp_q.push_back(mk_body(1'b1, i, 7));
      exp_q.push_back(mk_hdr(1'b0, i, 1));
      exp_q.push_back(mk_body(1'b0, i, 7));
    end
    fair_phase = 1'b1;
    wait_drain(100);
    fair_phase = 1'b0;
    check("fair_lane0_pkts", hdr_cnt0, 32'd10);
    check("fair_lane1_pkts", hdr_cnt1, 32'd10);

    // Reset in the middle of a lane1 len=5 packet.
    out_ready_and_i = 1'b0;
    src1.push_back(mk_hdr(1'b1, 20, 5));
    src1.push_back(mk_body(1'b1, 20, 1));
    src1.push_back(mk_body(1'b1, 20, 2));
    src1.push_back(mk_body(1'b1, 20, 3));
    exp_q.push_back(mk_hdr(1'b1, 20, 5));
    exp_q.push_back(mk_body(1'b1, 20, 1));
    exp_q.push_back(mk_body(1'b1, 20, 2));
    tick();
    tick();
    tick();
    tick();
    out_ready_and_i = 1'b1;
    tick();
    tick();
    tick();
    out_ready_and_i = 1'b0;
    check("mid_exp_empty", exp_q.size(), 0);
    check("mid_out_v", {31'd0, out_v_o}, 32'd1);
    check("mid_b3_head", out_data_o, mk_body(1'b1, 20, 3));
    check("mid_remaining", {28'd0, dut.rem_q}, 32'd3);
    rst_n = 1'b0;
    src0.delete();
    src1.delete();
    #1;
    check("mid_async_out_v", {31'd0, out_v_o}, 32'd0);
    check("mid_async_ready", {30'd0, in_ready_and_o}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready_and_i = 1'b1;
    tick();
    check("post_state_idle", {31'd0, dut.state_q}, {31'd0, WH_ST_IDLE});
    check("post_out_v", {31'd0, out_v_o}, 32'd0);
    src0.push_back(32'h0000_0042);
    exp_q.push_back(32'h0000_0042);
    tick();
    check("post_no_stale", {31'd0, out_v_o}, 32'd0);
    tick();
    check("post_first_flit", out_data_o, 32'h0000_0042);
    wait_drain(10);
    tick();
    check("post_idle_out_v", {31'd0, out_v_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always reaches its summary.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
